itcm_loader: RTL and testbench

- Write-side counterpart of the instruction fetch path.
- Receives a byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes those words into the ITCM write port, holding the CPU core in reset until the image is complete.
- Sits between the host/debug byte link and the ITCM; its cpu_hold output ORs into the core reset.

---
 rtl/itcm_loader_pkg.sv | 23 ++
 rtl/itcm_loader_if.sv | 17 +
 rtl/byte_packer.sv | 43 ++++
 rtl/itcm_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_itcm_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/itcm_loader_pkg.sv
// itcm_loader_pkg: shared types and constants for the ITCM image loader.
//   state_e   - loader FSM state encoding (3-bit)
//   MAGIC_DEF - default start-of-image marker byte
//   LEN_W     - width of the image word-count field
// Optional feature macro: ITCM_LOADER_CSUM_EN (adds the CSUM state).
package itcm_loader_pkg;

  localparam logic [7:0]  MAGIC_DEF = 8'hA5;
  localparam int unsigned LEN_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
`ifdef ITCM_LOADER_CSUM_EN
    ST_CSUM = 3'd4,
`endif
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

endpackage

// File: rtl/itcm_loader_if.sv
// itcm_loader_if: byte link (rx_v/rx_data/rx_rdy) plus ITCM write port
// (we/waddr/wdata) seen by the loader.
//   master - host/test side: drives the byte link, observes the write port
//   slave  - loader side: consumes the byte link, drives the write port
interface itcm_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              rx_v;
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (output rx_v, rx_data, input rx_rdy, we, waddr, wdata);
  modport slave  (input rx_v, rx_data, output rx_rdy, we, waddr, wdata);
endinterface

// File: rtl/byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from a byte stream.
//   clk, rst_n   - clock, async active-low reset
//   in_v_i       - byte accepted this cycle
//   in_data_i    - byte payload
//   clr_i        - restart at byte 0 (priority over in_v_i)
//   word_c_o     - assembled word, valid while word_v_c_o is high
//   word_v_c_o   - high in the cycle the 4th byte of a word is presented
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_v_i,
  input  logic [7:0]  in_data_i,
  input  logic        clr_i,
  output logic [31:0] word_c_o,
  output logic        word_v_c_o
);

  logic [1:0]  idx_q;
  logic [23:0] shift_q;

  // Bytes 0..2 are stored; byte 3 completes the word straight from the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (clr_i) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (in_v_i) begin
      case (idx_q)
        2'd0:    shift_q[7:0]   <= in_data_i;
        2'd1:    shift_q[15:8]  <= in_data_i;
        2'd2:    shift_q[23:16] <= in_data_i;
        default: shift_q        <= shift_q;
      endcase
      idx_q <= idx_q + 2'd1;
    end
  end

  assign word_c_o   = {in_data_i, shift_q};
  assign word_v_c_o = in_v_i && (idx_q == 2'd3);

endmodule

// File: rtl/itcm_loader.sv
// itcm_loader: receives an image over a byte link and writes it into the
// ITCM, holding the CPU core in reset until the image is complete.
// Image: MAGIC, LEN_LO, LEN_HI, then LEN*4 payload bytes (words LSB first).
//   clk, reset   - clock, async active-low reset
//   bus (slave)  - byte link in, ITCM write port out
//   cpu_hold     - keep core in reset while 1
//   done         - image loaded successfully
//   err          - sticky protocol error (cleared only by reset)
// Optional feature macro: ITCM_LOADER_CSUM_EN (trailing 8-bit sum byte).
module itcm_loader
  import itcm_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter logic [7:0]  MAGIC  = MAGIC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  itcm_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int unsigned CAP = 32'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              rx_rdy_q, rx_rdy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef ITCM_LOADER_CSUM_EN
  logic [7:0]        sum_q, sum_d;
`else
  logic              last_q, last_d;
`endif

  logic              acc_c;
  logic [LEN_W-1:0]  len_c;
  logic              pk_v_c, pk_clr_c;
  logic [31:0]       pk_word_c;
  logic              pk_word_v_c;

  assign acc_c = bus.rx_v && rx_rdy_q;
  assign len_c = {bus.rx_data, len_lo_q};

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .in_v_i     (pk_v_c),
    .in_data_i  (bus.rx_data),
    .clr_i      (pk_clr_c),
    .word_c_o   (pk_word_c),
    .word_v_c_o (pk_word_v_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_lo_q   <= 8'd0;
      rem_q      <= '0;
      wcnt_q     <= '0;
      rx_rdy_q   <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef ITCM_LOADER_CSUM_EN
      sum_q      <= 8'd0;
`else
      last_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      rem_q      <= rem_d;
      wcnt_q     <= wcnt_d;
      rx_rdy_q   <= rx_rdy_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef ITCM_LOADER_CSUM_EN
      sum_q      <= sum_d;
`else
      last_q     <= last_d;
`endif
    end
  end

  // Next state, datapath updates and next output values.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    wcnt_d   = wcnt_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    pk_v_c   = 1'b0;
    pk_clr_c = 1'b0;
`ifdef ITCM_LOADER_CSUM_EN
    sum_d    = sum_q;
`else
    last_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (acc_c && bus.rx_data == MAGIC) begin
          state_d = ST_LEN0;
`ifdef ITCM_LOADER_CSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      ST_LEN0: begin
        if (acc_c) begin
          len_lo_d = bus.rx_data;
          state_d  = ST_LEN1;
`ifdef ITCM_LOADER_CSUM_EN
          sum_d    = sum_q + bus.rx_data;
`endif
        end
      end
      ST_LEN1: begin
        if (acc_c) begin
          pk_clr_c = 1'b1;
          wcnt_d   = '0;
          rem_d    = len_c;
`ifdef ITCM_LOADER_CSUM_EN
          sum_d    = sum_q + bus.rx_data;
`endif
          if (len_c == '0) begin
`ifdef ITCM_LOADER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else if (32'(len_c) > CAP) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
`ifndef ITCM_LOADER_CSUM_EN
        // Leave one cycle after the final write strobe; a byte offered in
        // that cycle belongs to no image and is dropped.
        if (we_q && last_q) begin
          state_d = ST_DONE;
        end else
`endif
        begin
          pk_v_c = acc_c;
`ifdef ITCM_LOADER_CSUM_EN
          if (acc_c) sum_d = sum_q + bus.rx_data;
`endif
          if (pk_word_v_c) begin
            we_d    = 1'b1;
            waddr_d = wcnt_q;
            wdata_d = pk_word_c;
            wcnt_d  = wcnt_q + ADDR_W'(1);
            rem_d   = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
`ifdef ITCM_LOADER_CSUM_EN
              // Checksum byte may follow immediately, so switch now.
              state_d = ST_CSUM;
`else
              last_d  = 1'b1;
`endif
            end
          end
        end
      end
`ifdef ITCM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (acc_c) begin
          state_d = (bus.rx_data == sum_q) ? ST_DONE : ST_ERR;
        end
      end
`endif
      ST_DONE: begin
        if (acc_c && bus.rx_data == MAGIC) begin
          state_d = ST_LEN0;
`ifdef ITCM_LOADER_CSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rx_rdy_d   = (state_d != ST_ERR);
    cpu_hold_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  assign bus.rx_rdy = rx_rdy_q;
  assign bus.we     = we_q;
  assign bus.waddr  = waddr_q;
  assign bus.wdata  = wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_itcm_loader.sv
// tb_itcm_loader: directed self-checking bench for itcm_loader (ADDR_W=4).
// Honors ITCM_LOADER_CSUM_EN to match the build of the design.
module tb_itcm_loader;

  logic clk;
  logic reset;
  logic cpu_hold, done, err;

  itcm_loader_if #(.ADDR_W(4)) bus ();

  itcm_loader #(.ADDR_W(4), .MAGIC(8'hA5)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  int ncmp  = 0;
  int nfail = 0;

  logic [3:0]  log_addr[$];
  logic [31:0] log_data[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every ITCM write strobe.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.we === 1'b1) begin
      log_addr.push_back(bus.waddr);
      log_data.push_back(bus.wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.rx_v    = 1'b0;
    bus.rx_data = 8'h00;
    reset       = 1'b0;
    idle(2);
    reset       = 1'b1;
    idle(1);
    log_addr.delete();
    log_data.delete();
  endtask

  // Offer a byte from a negedge, wait for the handshake, return at the next negedge.
  task automatic send(input logic [7:0] b);
    int t = 0;
    bus.rx_v    = 1'b1;
    bus.rx_data = b;
    while (bus.rx_rdy !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.rx_rdy !== 1'b1) begin
      ncmp++;
      nfail++;
      $display("FAIL send_timeout: rx_rdy=%b required 1 for byte %h", bus.rx_rdy, b);
    end
    @(negedge clk);
    bus.rx_v = 1'b0;
  endtask

  // Present a byte for one cycle without waiting for acceptance.
  task automatic poke(input logic [7:0] b);
    bus.rx_v    = 1'b1;
    bus.rx_data = b;
    @(negedge clk);
    bus.rx_v    = 1'b0;
  endtask

  task automatic test_reset();
    bus.rx_v    = 1'b0;
    bus.rx_data = 8'h00;
    reset       = 1'b0;
    idle(2);
    ncmp++;
    if ({bus.rx_rdy, bus.we, bus.waddr, bus.wdata, cpu_hold, done, err} !==
        {1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      nfail++;
      $display("FAIL reset_values: rdy=%b we=%b waddr=%h wdata=%h hold=%b done=%b err=%b required 0 0 0 0 1 0 0",
               bus.rx_rdy, bus.we, bus.waddr, bus.wdata, cpu_hold, done, err);
    end
    reset = 1'b1;
    idle(1);
    ncmp++;
    if ({bus.rx_rdy, cpu_hold, done} !== 3'b110) begin
      nfail++;
      $display("FAIL reset_release: rdy/hold/done=%b required 110", {bus.rx_rdy, cpu_hold, done});
    end
  endtask

  task automatic test_basic();
    logic [7:0] img [11] = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                             8'h78, 8'h56, 8'h34, 8'h12};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send(img[i]);
      if (i == 6) begin
        ncmp++;
        if ({bus.we, bus.waddr, bus.wdata} !== {1'b1, 4'd0, 32'hDEADBEEF}) begin
          nfail++;
          $display("FAIL basic_word0: we=%b waddr=%h wdata=%h required 1 0 deadbeef",
                   bus.we, bus.waddr, bus.wdata);
        end
      end
    end
    ncmp++;
    if ({bus.we, bus.waddr, bus.wdata, done} !== {1'b1, 4'd1, 32'h12345678, 1'b0}) begin
      nfail++;
      $display("FAIL basic_word1: we=%b waddr=%h wdata=%h done=%b required 1 1 12345678 0",
               bus.we, bus.waddr, bus.wdata, done);
    end
`ifdef ITCM_LOADER_CSUM_EN
    send(8'h4E);
`else
    idle(1);
`endif
    ncmp++;
    if ({bus.we, done, cpu_hold, err} !== 4'b0100) begin
      nfail++;
      $display("FAIL basic_done: we/done/hold/err=%b required 0100", {bus.we, done, cpu_hold, err});
    end
    ncmp++;
    if (log_addr.size() != 2) begin
      nfail++;
      $display("FAIL basic_wr_count: got %0d required 2", log_addr.size());
    end
  endtask

  // Runs from DONE: MAGIC reloads, then a zero-length image completes.
  task automatic test_reload_zero();
    log_addr.delete();
    log_data.delete();
    send(8'hA5);
    ncmp++;
    if ({done, cpu_hold} !== 2'b01) begin
      nfail++;
      $display("FAIL reload_hold: done/hold=%b required 01", {done, cpu_hold});
    end
    send(8'h00);
    send(8'h00);
`ifdef ITCM_LOADER_CSUM_EN
    send(8'h00);
`endif
    ncmp++;
    if ({done, cpu_hold, err} !== 3'b100) begin
      nfail++;
      $display("FAIL zero_len_done: done/hold/err=%b required 100", {done, cpu_hold, err});
    end
    idle(1);
    ncmp++;
    if (log_addr.size() != 0) begin
      nfail++;
      $display("FAIL zero_len_no_write: got %0d writes required 0", log_addr.size());
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send(8'hA5);
    send(8'h11);
    send(8'h00);
    ncmp++;
    if ({err, bus.rx_rdy, cpu_hold, done} !== 4'b1010) begin
      nfail++;
      $display("FAIL oversize_err: err/rdy/hold/done=%b required 1010", {err, bus.rx_rdy, cpu_hold, done});
    end
    poke(8'hA5);
    poke(8'h00);
    poke(8'h00);
    idle(2);
    ncmp++;
    if ({err, bus.rx_rdy, cpu_hold, done, bus.we} !== 5'b10100) begin
      nfail++;
      $display("FAIL oversize_sticky: err/rdy/hold/done/we=%b required 10100",
               {err, bus.rx_rdy, cpu_hold, done, bus.we});
    end
    ncmp++;
    if (log_addr.size() != 0) begin
      nfail++;
      $display("FAIL oversize_no_write: got %0d writes required 0", log_addr.size());
    end
  endtask

  // N == 2**ADDR_W is the largest legal image: fills every word.
  task automatic test_full_capacity();
    do_reset();
    send(8'hA5);
    send(8'h10);
    send(8'h00);
    ncmp++;
    if ({err, bus.rx_rdy} !== 2'b01) begin
      nfail++;
      $display("FAIL full_accepted: err/rdy=%b required 01", {err, bus.rx_rdy});
    end
    for (int i = 0; i < 64; i++) send(8'(i));
`ifdef ITCM_LOADER_CSUM_EN
    send(8'hF0);
`else
    idle(1);
`endif
    ncmp++;
    if ({done, err} !== 2'b10) begin
      nfail++;
      $display("FAIL full_done: done/err=%b required 10", {done, err});
    end
    ncmp++;
    if (log_addr.size() != 16) begin
      nfail++;
      $display("FAIL full_wr_count: got %0d required 16", log_addr.size());
    end else begin
      ncmp++;
      if ({log_addr[15], log_data[15]} !== {4'd15, 32'h3F3E3D3C}) begin
        nfail++;
        $display("FAIL full_last_word: waddr=%h wdata=%h required f 3f3e3d3c", log_addr[15], log_data[15]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] img [9] = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(img[i]);
      idle(3);
    end
`ifdef ITCM_LOADER_CSUM_EN
    send(8'hAB);
    idle(1);
`endif
    ncmp++;
    if (log_addr.size() != 1) begin
      nfail++;
      $display("FAIL gaps_wr_count: got %0d required 1", log_addr.size());
    end else begin
      ncmp++;
      if ({log_addr[0], log_data[0]} !== {4'd0, 32'h44332211}) begin
        nfail++;
        $display("FAIL gaps_word: waddr=%h wdata=%h required 0 44332211", log_addr[0], log_data[0]);
      end
    end
    ncmp++;
    if ({done, cpu_hold} !== 2'b10) begin
      nfail++;
      $display("FAIL gaps_done: done/hold=%b required 10", {done, cpu_hold});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] img [11] = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                             8'h78, 8'h56, 8'h34, 8'h12};
    do_reset();
    send(8'hA5);
    send(8'h02);
    send(8'h00);
    send(8'h01);
    send(8'h02);
    reset = 1'b0;
    #1;
    ncmp++;
    if ({bus.we, cpu_hold, done, bus.rx_rdy} !== 4'b0100) begin
      nfail++;
      $display("FAIL midreset_outputs: we/hold/done/rdy=%b required 0100", {bus.we, cpu_hold, done, bus.rx_rdy});
    end
    idle(2);
    reset = 1'b1;
    idle(1);
    ncmp++;
    if (log_addr.size() != 0) begin
      nfail++;
      $display("FAIL midreset_no_write: got %0d writes required 0", log_addr.size());
    end
    for (int i = 0; i < 11; i++) send(img[i]);
`ifdef ITCM_LOADER_CSUM_EN
    send(8'h4E);
`else
    idle(1);
`endif
    ncmp++;
    if (log_addr.size() != 2) begin
      nfail++;
      $display("FAIL midreset_reload_count: got %0d required 2", log_addr.size());
    end else begin
      ncmp++;
      if ({log_addr[0], log_data[0], log_addr[1], log_data[1]} !==
          {4'd0, 32'hDEADBEEF, 4'd1, 32'h12345678}) begin
        nfail++;
        $display("FAIL midreset_reload_words: %h:%h %h:%h required 0:deadbeef 1:12345678",
                 log_addr[0], log_data[0], log_addr[1], log_data[1]);
      end
    end
    ncmp++;
    if ({done, cpu_hold} !== 2'b10) begin
      nfail++;
      $display("FAIL midreset_done: done/hold=%b required 10", {done, cpu_hold});
    end
  endtask

`ifdef ITCM_LOADER_CSUM_EN
  task automatic test_csum();
    logic [7:0] img [7] = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    do_reset();
    for (int i = 0; i < 7; i++) send(img[i]);
    send(8'h0B);
    ncmp++;
    if ({done, err, cpu_hold} !== 3'b100) begin
      nfail++;
      $display("FAIL csum_good: done/err/hold=%b required 100", {done, err, cpu_hold});
    end
    do_reset();
    for (int i = 0; i < 7; i++) send(img[i]);
    send(8'h0C);
    ncmp++;
    if ({done, err, cpu_hold, bus.rx_rdy} !== 4'b0110) begin
      nfail++;
      $display("FAIL csum_bad: done/err/hold/rdy=%b required 0110", {done, err, cpu_hold, bus.rx_rdy});
    end
  endtask
`endif

  initial begin
    reset       = 1'b0;
    bus.rx_v    = 1'b0;
    bus.rx_data = 8'h00;
    test_reset();
    test_basic();
    test_reload_zero();
    test_oversize();
    test_full_capacity();
    test_gaps();
    test_reset_mid();
`ifdef ITCM_LOADER_CSUM_EN
    test_csum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
